// File: rtl/mem_rd_arbiter_if.sv
// Requester/memory bundle for mem_rd_arbiter: master is the arbiter side,
// slave is the requester/memory side.
interface mem_rd_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int ABITS = 8,
  parameter int DBITS = 16,
  parameter int LBITS = 4
);
  logic [NREQ-1:0]       req;
  logic [NREQ*ABITS-1:0] req_addr;
  logic [NREQ*LBITS-1:0] req_len;
  logic [NREQ-1:0]       gnt;
  logic                  rd_en;
  logic [ABITS-1:0]      rd_addr;
  logic [DBITS-1:0]      rd_data;
  logic [NREQ-1:0]       rsp_valid;
  logic [DBITS-1:0]      rsp_data;
  logic                  rsp_last;
  logic                  busy;

  modport master (
    input  req, req_addr, req_len, rd_data,
    output gnt, rd_en, rd_addr, rsp_valid, rsp_data, rsp_last, busy
  );

  modport slave (
    output req, req_addr, req_len, rd_data,
    input  gnt, rd_en, rd_addr, rsp_valid, rsp_data, rsp_last, busy
  );
endinterface

// File: rtl/mem_rd_arbiter.sv
// Round-robin burst-read arbiter sharing one synchronous-read memory port.
// Optional MEMARB_PRIO0_EN: requester 0 has absolute priority over the rest.
//
// state | meaning
// IDLE  | no burst in flight; arbitrate and grant
// ISSUE | driving rd_en with consecutive addresses, one per cycle
// DRAIN | issue done; waiting for the final word to be returned
module mem_rd_arbiter #(
  parameter int NREQ   = 4,
  parameter int ABITS  = 8,
  parameter int DBITS  = 16,
  parameter int LBITS  = 4,
  parameter int RD_LAT = 1
) (
  input logic               i_clk,
  input logic               i_rst,
  mem_rd_arbiter_if.master  io_bus
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [PW-1:0]     r_rr_ptr;
  logic [PW-1:0]     r_owner;
  logic [PW-1:0]     w_winner;
  logic              w_found;
  logic [NREQ-1:0]   w_gnt;
  logic              r_rd_en;
  logic [ABITS-1:0]  r_rd_addr;
  logic [LBITS-1:0]  r_left;
  logic [RD_LAT-1:0] r_pipe_vld;
  logic [RD_LAT-1:0] r_pipe_last;
  logic [NREQ-1:0]   r_rsp_valid;
  logic [DBITS-1:0]  r_rsp_data;
  logic              r_rsp_last;
  logic              w_issue;
  logic              w_issue_last;

  assign w_issue      = (r_state == ISSUE);
  assign w_issue_last = w_issue && (r_left == '0);

  always_comb begin : p_arb
    logic [PW-1:0] idx;
    idx      = '0;
    w_found  = 1'b0;
    w_winner = '0;
`ifdef MEMARB_PRIO0_EN
    if (io_bus.req[0]) begin
      w_found  = 1'b1;
      w_winner = '0;
    end else
`endif
    begin
      for (int j = 0; j < NREQ; j++) begin
        idx = PW'((int'(r_rr_ptr) + j) % NREQ);
`ifdef MEMARB_PRIO0_EN
        if (!w_found && io_bus.req[idx] && (idx != '0)) begin
`else
        if (!w_found && io_bus.req[idx]) begin
`endif
          w_found  = 1'b1;
          w_winner = idx;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gnt       = '0;
    case (r_state)
      IDLE: begin
        if (w_found && !i_rst) begin
          w_gnt       = NREQ'(1) << w_winner;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE:   if (r_left == '0) w_state_nxt = DRAIN;
      DRAIN:   if (r_rsp_last)   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rr_ptr    <= '0;
      r_owner     <= '0;
      r_rd_en     <= 1'b0;
      r_rd_addr   <= '0;
      r_left      <= '0;
      r_pipe_vld  <= '0;
      r_pipe_last <= '0;
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      r_rsp_last  <= 1'b0;
    end else begin
      // Valid/last tokens travel alongside the memory latency.
      r_pipe_vld[0]  <= w_issue;
      r_pipe_last[0] <= w_issue_last;
      for (int i = 1; i < RD_LAT; i++) begin
        r_pipe_vld[i]  <= r_pipe_vld[i-1];
        r_pipe_last[i] <= r_pipe_last[i-1];
      end

      r_rsp_valid <= '0;
      r_rsp_last  <= r_pipe_last[RD_LAT-1];
      if (r_pipe_vld[RD_LAT-1]) begin
        r_rsp_valid <= NREQ'(1) << r_owner;
        r_rsp_data  <= io_bus.rd_data;
      end

      case (r_state)
        IDLE: begin
          if (|w_gnt) begin
            r_owner   <= w_winner;
            r_rd_en   <= 1'b1;
            r_rd_addr <= io_bus.req_addr[w_winner*ABITS +: ABITS];
            r_left    <= io_bus.req_len[w_winner*LBITS +: LBITS];
`ifdef MEMARB_PRIO0_EN
            if (w_winner != '0)
`endif
            r_rr_ptr  <= PW'((int'(w_winner) + 1) % NREQ);
          end
        end
        ISSUE: begin
          if (r_left == '0) begin
            r_rd_en <= 1'b0;
          end else begin
            r_left    <= r_left - 1'b1;
            r_rd_addr <= r_rd_addr + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign io_bus.gnt       = w_gnt;
  assign io_bus.rd_en     = r_rd_en;
  assign io_bus.rd_addr   = r_rd_addr;
  assign io_bus.rsp_valid = r_rsp_valid;
  assign io_bus.rsp_data  = r_rsp_data;
  assign io_bus.rsp_last  = r_rsp_last;
  assign io_bus.busy      = (r_state != IDLE);

endmodule

// File: tb/tb_mem_rd_arbiter.sv
// Bench for mem_rd_arbiter: directed bursts plus random traffic, checked
// cycle by cycle against a burst-level timing model and a 1-cycle memory.
module tb_mem_rd_arbiter;
  localparam int NREQ  = 4;
  localparam int ABITS = 8;
  localparam int DBITS = 16;
  localparam int LBITS = 4;
  localparam int L     = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_rd_arbiter_if #(.NREQ(NREQ), .ABITS(ABITS), .DBITS(DBITS), .LBITS(LBITS)) bus ();

  mem_rd_arbiter #(
    .NREQ(NREQ), .ABITS(ABITS), .DBITS(DBITS), .LBITS(LBITS), .RD_LAT(L)
  ) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus)
  );

  always @(posedge clk)
    if (bus.rd_en) bus.rd_data <= {8'h00, bus.rd_addr} ^ 16'hA5A5;

  int n_checks = 0;
  int n_errors = 0;
  int rr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int model_winner(input logic [NREQ-1:0] r);
`ifdef MEMARB_PRIO0_EN
    if (r[0]) return 0;
`endif
    for (int j = 0; j < NREQ; j++) begin
      int idx;
      idx = (rr + j) % NREQ;
`ifdef MEMARB_PRIO0_EN
      if (idx == 0) continue;
`endif
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic set_slot(input int i, input logic [7:0] a, input logic [3:0] n);
    bus.req_addr[i*ABITS +: ABITS] = a;
    bus.req_len[i*LBITS +: LBITS]  = n;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Entered in the grant cycle with req already driven; returns in the
  // first cycle after busy falls.
  task automatic burst(input bit drop, input logic [NREQ-1:0] raise);
    int w, len, k;
    logic [7:0] base, a;
    logic [NREQ-1:0] oh;
    w = model_winner(bus.req);
    n_checks++;
    assert (w >= 0) else begin
      n_errors++;
      $error("FAIL no_request: observed req %0h expected nonzero", bus.req);
    end
    if (w < 0) return;
    base = bus.req_addr[w*ABITS +: ABITS];
    len  = int'(bus.req_len[w*LBITS +: LBITS]);
    oh   = NREQ'(1) << w;
    @(negedge clk);
    chk("gnt", 32'(bus.gnt), 32'(oh));
    chk("busy_at_gnt", 32'(bus.busy), 32'(0));
    chk("rd_en_at_gnt", 32'(bus.rd_en), 32'(0));
`ifdef MEMARB_PRIO0_EN
    if (w != 0) rr = (w + 1) % NREQ;
`else
    rr = (w + 1) % NREQ;
`endif
    for (int c = 1; c <= len + 2 + L; c++) begin
      next_cycle();
      if (c == 1 && drop) begin
        bus.req[w] = 1'b0;
        set_slot(w, 8'($urandom), 4'($urandom));
      end
      if (c == 2) bus.req = bus.req | raise;
      @(negedge clk);
      chk("gnt_busy", 32'(bus.gnt), 32'(0));
      chk("busy", 32'(bus.busy), 32'(1));
      chk("rd_en", 32'(bus.rd_en), 32'(c <= len + 1));
      if (c <= len + 1) begin
        a = 8'(int'(base) + c - 1);
        chk("rd_addr", 32'(bus.rd_addr), 32'(a));
      end
      k = c - 2 - L;
      if (k >= 0 && k <= len) begin
        a = 8'(int'(base) + k);
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(oh));
        chk("rsp_data", 32'(bus.rsp_data), 32'({8'h00, a} ^ 16'hA5A5));
      end else begin
        chk("rsp_valid_idle", 32'(bus.rsp_valid), 32'(0));
      end
      chk("rsp_last", 32'(bus.rsp_last), 32'(k == len));
    end
    next_cycle();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    rr = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"},       32'(bus.gnt),       32'(0));
    chk({tag, "_rd_en"},     32'(bus.rd_en),     32'(0));
    chk({tag, "_rd_addr"},   32'(bus.rd_addr),   32'(0));
    chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'(0));
    chk({tag, "_rsp_data"},  32'(bus.rsp_data),  32'(0));
    chk({tag, "_rsp_last"},  32'(bus.rsp_last),  32'(0));
    chk({tag, "_busy"},      32'(bus.busy),      32'(0));
  endtask

  initial begin
    logic [NREQ-1:0] m;
    rst = 1'b1;
    bus.req = '0;
    bus.req_addr = '0;
    bus.req_len = '0;
    do_reset();
    @(negedge clk);
    chk_all_zero("reset");
    next_cycle();

    // single burst
    set_slot(2, 8'h10, 4'd3);
    bus.req = 4'b0100;
    burst(1'b1, '0);

    // address wrap
    set_slot(1, 8'hFE, 4'd3);
    bus.req = 4'b0010;
    burst(1'b1, '0);

    // request drop with requester 0 raising mid-burst
    set_slot(3, 8'h80, 4'd7);
    set_slot(0, 8'h20, 4'd1);
    bus.req = 4'b1000;
    burst(1'b1, 4'b0001);
    burst(1'b1, '0);

    // reset mid-burst
    do_reset();
    set_slot(2, 8'h40, 4'd7);
    bus.req = 4'b0100;
    @(negedge clk);
    chk("mid_gnt", 32'(bus.gnt), 32'(4'b0100));
    next_cycle();
    bus.req = '0;
    @(negedge clk);
    chk("mid_rd_addr", 32'(bus.rd_addr), 32'(8'h40));
    next_cycle();
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    rr = 0;
    @(negedge clk);
    chk_all_zero("after_rst");
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      @(negedge clk);
      chk("post_rst_rsp_valid", 32'(bus.rsp_valid), 32'(0));
      chk("post_rst_rsp_last", 32'(bus.rsp_last), 32'(0));
      chk("post_rst_busy", 32'(bus.busy), 32'(0));
    end
    next_cycle();
    set_slot(1, 8'h33, 4'd2);
    set_slot(3, 8'h44, 4'd2);
    bus.req = 4'b1010;
    burst(1'b1, '0);

    // all requesters held high, single-word bursts
    do_reset();
    for (int i = 0; i < NREQ; i++) set_slot(i, 8'(16 * i), 4'd0);
    bus.req = 4'b1111;
    for (int i = 0; i < 5; i++) burst(1'b0, '0);
`ifdef MEMARB_PRIO0_EN
    bus.req[0] = 1'b0;
    for (int i = 0; i < 4; i++) burst(1'b0, '0);
`endif

    // random traffic
    for (int it = 0; it < 30; it++) begin
      for (int i = 0; i < NREQ; i++) set_slot(i, 8'($urandom), 4'($urandom));
      m = 4'($urandom_range(1, 15));
      if ($urandom_range(0, 3) == 0) begin
        bus.req = '0;
        @(negedge clk);
        chk("idle_gnt", 32'(bus.gnt), 32'(0));
        chk("idle_busy", 32'(bus.busy), 32'(0));
        next_cycle();
      end
      bus.req = m;
      burst(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
